// File: rtl/jacaranda_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding and frame constants.
package jacaranda_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    DATA = 3'd2,
    CSUM = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } state_t;

  // A LEN byte of zero encodes a full 256-byte image.
  localparam bit LEN_ZERO_MEANS_256 = 1'b1;

  localparam int unsigned TMO_WIDTH = 16;

endpackage

// File: rtl/imem_loader_timeout.sv
// Idle-cycle counter for the loader; flags when the gap between frame bytes reaches the limit.
module imem_loader_timeout
  import jacaranda_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_clear,
  input  logic i_count,
  output logic o_expired
);

  localparam logic [TMO_WIDTH-1:0] LIMIT = TMO_WIDTH'(TIMEOUT_CYCLES);

  logic [TMO_WIDTH-1:0] r_count;

  // Saturates at the limit so the flag stays up until the next clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_count && !o_expired) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = (r_count == LIMIT);

endmodule

// File: rtl/imem_loader.sv
// Receives a framed program image (LEN, payload, CSUM) and writes it into instruction memory,
// holding the CPU in reset until a frame with a good checksum has been loaded.
module imem_loader
  import jacaranda_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       load_req,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  input  logic [7:0] cpu_pc,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_w_data,
  output logic       mem_w_en,
  output logic       cpu_reset,
  output logic       busy,
  output logic       done,
  output logic       error
);

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_wr_ptr;
  logic [7:0] r_sum;
  logic [8:0] r_remain;
  logic [7:0] r_mem_w_data;
  logic       r_mem_w_en;

  logic       w_active;
  logic       w_xfer;
  logic       w_start;
  logic       w_tmo_hit;
  logic [7:0] w_csum_total;

  assign w_active     = (r_state == LEN) || (r_state == DATA) || (r_state == CSUM);
  assign w_xfer       = rx_valid && w_active;
  assign w_start      = load_req && ((r_state == IDLE) || (r_state == DONE) || (r_state == ERR));
  assign w_csum_total = r_sum + rx_data;

  imem_loader_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock    (clock),
    .reset_n  (reset_n),
    .i_clear  (w_start || w_xfer),
    .i_count  (w_active && !w_xfer),
    .o_expired(w_tmo_hit)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // A byte arriving in the same cycle as the timeout still counts as activity.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE, ERR: if (load_req) w_next = LEN;
      LEN: begin
        if (w_xfer)         w_next = DATA;
        else if (w_tmo_hit) w_next = ERR;
      end
      DATA: begin
        if (w_xfer) begin
          if (r_remain == 9'd1) w_next = CSUM;
        end else if (w_tmo_hit) begin
          w_next = ERR;
        end
      end
      CSUM: begin
        if (w_xfer)         w_next = (w_csum_total == 8'h00) ? DONE : ERR;
        else if (w_tmo_hit) w_next = ERR;
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    rx_ready  = w_active;
    busy      = w_active;
    done      = (r_state == DONE);
    error     = (r_state == ERR);
    cpu_reset = (r_state != DONE);
  end

  // Pointer advances after each write, so the write cycle always presents the current slot.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr     <= '0;
      r_sum        <= '0;
      r_remain     <= '0;
      r_mem_w_data <= '0;
      r_mem_w_en   <= 1'b0;
    end else begin
      r_mem_w_en <= 1'b0;
      if (r_mem_w_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_start)    r_sum    <= '0;
      if (w_xfer) begin
        case (r_state)
          LEN: begin
            r_remain <= ((rx_data == 8'h00) && LEN_ZERO_MEANS_256) ? 9'd256 : {1'b0, rx_data};
            r_wr_ptr <= '0;
            r_sum    <= rx_data;
          end
          DATA: begin
            r_sum        <= w_csum_total;
            r_remain     <= r_remain - 9'd1;
            r_mem_w_data <= rx_data;
            r_mem_w_en   <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign mem_w_en   = r_mem_w_en;
  assign mem_w_data = r_mem_w_data;
  assign mem_addr   = (w_active || r_mem_w_en) ? r_wr_ptr : cpu_pc;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good/bad frames, 256-byte image, idle timeout, ignored
// load requests and asynchronous reset in the middle of a frame.
module tb_imem_loader;

  localparam int unsigned TMO = 16;

  logic       clock = 1'b0;
  logic       resetN;
  logic       loadReq;
  logic [7:0] rxData;
  logic       rxValid;
  logic       rxReady;
  logic [7:0] cpuPc;
  logic [7:0] memAddr;
  logic [7:0] memWData;
  logic       memWEn;
  logic       cpuReset;
  logic       busy;
  logic       done;
  logic       error;

  int testsRun    = 0;
  int testsFailed = 0;

  int         wrCount = 0;
  logic [7:0] wrAddr[1024];
  logic [7:0] wrData[1024];

  imem_loader #(
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock     (clock),
    .reset_n   (resetN),
    .load_req  (loadReq),
    .rx_data   (rxData),
    .rx_valid  (rxValid),
    .rx_ready  (rxReady),
    .cpu_pc    (cpuPc),
    .mem_addr  (memAddr),
    .mem_w_data(memWData),
    .mem_w_en  (memWEn),
    .cpu_reset (cpuReset),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clock = ~clock;

  // Log every memory write seen mid-cycle.
  always @(negedge clock) begin
    if (memWEn) begin
      if (wrCount < 1024) begin
        wrAddr[wrCount] = memAddr;
        wrData[wrCount] = memWData;
      end
      wrCount++;
    end
  end

  task pulse_load();
    loadReq = 1'b1;
    @(posedge clock);
    #1 loadReq = 1'b0;
  endtask

  task send_byte(input logic [7:0] b);
    rxData  = b;
    rxValid = 1'b1;
    @(posedge clock);
    #1 rxValid = 1'b0;
  endtask

  task idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task test_reset();
    #1;
    testsRun++;
    if ({memWEn, memWData, cpuReset, busy, done, error, rxReady} !== {1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      testsFailed++;
      $display("[TB] FAIL reset_outputs: got wen=%b wdata=%h cpurst=%b busy=%b done=%b err=%b rdy=%b expected 0 00 1 0 0 0 0",
               memWEn, memWData, cpuReset, busy, done, error, rxReady);
    end
    testsRun++;
    if (memAddr !== cpuPc) begin
      testsFailed++;
      $display("[TB] FAIL reset_addr_mux: got %h expected %h", memAddr, cpuPc);
    end
    @(posedge clock);
    #1 resetN = 1'b1;
  endtask

  task test_good_frame();
    int base;
    base  = wrCount;
    cpuPc = 8'h40;
    pulse_load();
    testsRun++;
    if ({busy, cpuReset, rxReady} !== 3'b111) begin
      testsFailed++;
      $display("[TB] FAIL good_busy: got busy/cpurst/rdy=%b expected 111", {busy, cpuReset, rxReady});
    end
    testsRun++;
    if (memAddr !== 8'h00) begin
      testsFailed++;
      $display("[TB] FAIL good_addr_during_load: got %h expected 00", memAddr);
    end
    // Checksum covers the LEN byte too: 03+11+22+33 = 69, so CSUM = 97.
    send_byte(8'h03);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h97);
    testsRun++;
    if (wrCount - base !== 3) begin
      testsFailed++;
      $display("[TB] FAIL good_write_count: got %0d expected 3", wrCount - base);
    end
    for (int i = 0; i < 3; i++) begin
      testsRun++;
      if (wrAddr[base+i] !== 8'(i) || wrData[base+i] !== 8'(8'h11 * (i + 1))) begin
        testsFailed++;
        $display("[TB] FAIL good_write_%0d: got addr=%h data=%h expected addr=%h data=%h",
                 i, wrAddr[base+i], wrData[base+i], 8'(i), 8'(8'h11 * (i + 1)));
      end
    end
    cpuPc = 8'hC3;
    #1;
    testsRun++;
    if ({done, error, busy, cpuReset, memWEn} !== 5'b10000) begin
      testsFailed++;
      $display("[TB] FAIL good_status: got done/err/busy/cpurst/wen=%b expected 10000",
               {done, error, busy, cpuReset, memWEn});
    end
    testsRun++;
    if (memAddr !== 8'hC3) begin
      testsFailed++;
      $display("[TB] FAIL good_addr_follows_pc: got %h expected c3", memAddr);
    end
  endtask

  task test_bad_checksum();
    send_byte(8'h00);
    pulse_load();
    send_byte(8'h03);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h00);
    testsRun++;
    if ({error, done, cpuReset, busy} !== 4'b1010) begin
      testsFailed++;
      $display("[TB] FAIL bad_status: got err/done/cpurst/busy=%b expected 1010", {error, done, cpuReset, busy});
    end
    pulse_load();
    testsRun++;
    if ({error, busy} !== 2'b01) begin
      testsFailed++;
      $display("[TB] FAIL bad_reload_clears: got err/busy=%b expected 01", {error, busy});
    end
    send_byte(8'h01);
    send_byte(8'h5A);
    send_byte(8'hA5);
    testsRun++;
    if ({done, error, cpuReset} !== 3'b100) begin
      testsFailed++;
      $display("[TB] FAIL bad_recover: got done/err/cpurst=%b expected 100", {done, error, cpuReset});
    end
  endtask

  task test_len_zero();
    int base;
    int bad;
    base = wrCount;
    bad  = 0;
    pulse_load();
    send_byte(8'h00);
    for (int i = 0; i < 256; i++) send_byte(8'(i));
    send_byte(8'h80);
    testsRun++;
    if (wrCount - base !== 256) begin
      testsFailed++;
      $display("[TB] FAIL len0_write_count: got %0d expected 256", wrCount - base);
    end
    for (int i = 0; i < 256; i++) begin
      if (wrAddr[base+i] !== 8'(i) || wrData[base+i] !== 8'(i)) bad++;
    end
    testsRun++;
    if (bad !== 0) begin
      testsFailed++;
      $display("[TB] FAIL len0_write_contents: got %0d wrong writes expected 0", bad);
    end
    testsRun++;
    if ({done, error} !== 2'b10) begin
      testsFailed++;
      $display("[TB] FAIL len0_done: got done/err=%b expected 10", {done, error});
    end
    cpuPc = 8'h77;
    pulse_load();
    testsRun++;
    if (memAddr !== 8'h00) begin
      testsFailed++;
      $display("[TB] FAIL len0_ptr_wrap: got %h expected 00", memAddr);
    end
    send_byte(8'h01);
    send_byte(8'h10);
    send_byte(8'hEF);
    testsRun++;
    if (done !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL len0_followup_done: got %b expected 1", done);
    end
  endtask

  task test_timeout();
    int base;
    base = wrCount;
    pulse_load();
    idle(10);
    send_byte(8'h02);
    idle(10);
    send_byte(8'h01);
    idle(10);
    send_byte(8'h02);
    idle(10);
    send_byte(8'hFB);
    testsRun++;
    if ({done, error} !== 2'b10) begin
      testsFailed++;
      $display("[TB] FAIL gaps_done: got done/err=%b expected 10", {done, error});
    end
    testsRun++;
    if (wrCount - base !== 2 || wrAddr[base+1] !== 8'h01 || wrData[base+1] !== 8'h02) begin
      testsFailed++;
      $display("[TB] FAIL gaps_writes: got count=%0d addr=%h data=%h expected 2 01 02",
               wrCount - base, wrAddr[base+1], wrData[base+1]);
    end
    pulse_load();
    send_byte(8'h03);
    send_byte(8'hAA);
    idle(16);
    testsRun++;
    if ({busy, error} !== 2'b10) begin
      testsFailed++;
      $display("[TB] FAIL stall16_still_busy: got busy/err=%b expected 10", {busy, error});
    end
    idle(1);
    testsRun++;
    if ({error, busy, cpuReset, rxReady, done} !== 5'b10100) begin
      testsFailed++;
      $display("[TB] FAIL stall17_error: got err/busy/cpurst/rdy/done=%b expected 10100",
               {error, busy, cpuReset, rxReady, done});
    end
  endtask

  task test_back_to_back();
    int base;
    base = wrCount;
    pulse_load();
    send_byte(8'h04);
    send_byte(8'h01);
    loadReq = 1'b1;
    rxData  = 8'h02;
    rxValid = 1'b1;
    @(posedge clock);
    #1;
    loadReq = 1'b0;
    rxValid = 1'b0;
    testsRun++;
    if ({busy, done, error} !== 3'b100) begin
      testsFailed++;
      $display("[TB] FAIL ignore_load_busy: got busy/done/err=%b expected 100", {busy, done, error});
    end
    send_byte(8'h03);
    send_byte(8'h04);
    send_byte(8'hF2);
    testsRun++;
    if (done !== 1'b1 || wrCount - base !== 4 || wrAddr[base+3] !== 8'h03 || wrData[base+3] !== 8'h04) begin
      testsFailed++;
      $display("[TB] FAIL ignore_load_frame: got done=%b count=%0d addr=%h data=%h expected 1 4 03 04",
               done, wrCount - base, wrAddr[base+3], wrData[base+3]);
    end
    cpuPc = 8'h2C;
    pulse_load();
    send_byte(8'h03);
    send_byte(8'h55);
    send_byte(8'h66);
    testsRun++;
    if ({memWEn, memWData} !== {1'b1, 8'h66}) begin
      testsFailed++;
      $display("[TB] FAIL midframe_write: got wen=%b data=%h expected 1 66", memWEn, memWData);
    end
    #2 resetN = 1'b0;
    #1;
    testsRun++;
    if ({memWEn, memWData, cpuReset, busy, done, error, rxReady} !== {1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      testsFailed++;
      $display("[TB] FAIL async_reset_outputs: got wen=%b wdata=%h cpurst=%b busy=%b done=%b err=%b rdy=%b expected 0 00 1 0 0 0 0",
               memWEn, memWData, cpuReset, busy, done, error, rxReady);
    end
    testsRun++;
    if (memAddr !== 8'h2C) begin
      testsFailed++;
      $display("[TB] FAIL async_reset_addr: got %h expected 2c", memAddr);
    end
    @(posedge clock);
    #1 resetN = 1'b1;
  endtask

  initial begin
    resetN  = 1'b0;
    loadReq = 1'b0;
    rxData  = 8'h00;
    rxValid = 1'b0;
    cpuPc   = 8'h5A;
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_len_zero();
    test_timeout();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
